// File: rtl/interval_timer.sv
// interval_timer
// Companion timer for the traffic-light controller. The controller pulses or
// holds IC to restart timing; this block counts prescaled ticks and raises
// S once SHORT_CYCLES ticks have elapsed and L once LONG_CYCLES ticks have
// elapsed. Both flags are registered, saturating levels held until the next
// IC or reset.
//
// Ports:
//   clk   in   1      system clock, rising-edge
//   CLR   in   1      synchronous active-low reset
//   IC    in   1      initialize count, level-sampled each edge
//   S     out  1      short interval elapsed (registered level)
//   L     out  1      long interval elapsed (registered level)
//   BUSY  out  1      timer running (RUN_S or RUN_L)
//   CNT   out  WIDTH  current tick count
module interval_timer #(
  parameter int WIDTH        = 8,
  parameter int SHORT_CYCLES = 5,
  parameter int LONG_CYCLES  = 25,
  parameter int TICK_DIV     = 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             IC,
  output logic             S,
  output logic             L,
  output logic             BUSY,
  output logic [WIDTH-1:0] CNT
);

  // A divider of 1 still gets a one-bit prescaler that simply stays at 0.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] SHORT_W = WIDTH'(SHORT_CYCLES);
  localparam logic [WIDTH-1:0] LONG_W  = WIDTH'(LONG_CYCLES);

  // Reject parameter sets that could not produce a sane short/long ordering
  // or that would let the counter overflow.
  if (!(SHORT_CYCLES >= 1 && SHORT_CYCLES < LONG_CYCLES &&
        longint'(LONG_CYCLES) <= ((longint'(1) << WIDTH) - 1) &&
        TICK_DIV >= 1)) begin : gBadParams
    $error("interval_timer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_S = 2'd1,
    RUN_L = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [PW-1:0]    prescaler;
  logic [PW-1:0]    prescalerNext;
  logic [WIDTH-1:0] cntNext;
  logic [WIDTH-1:0] cntInc;
  logic             sNext;
  logic             lNext;
  logic             busyNext;
  logic             tick;

  assign tick   = (prescaler == PRE_MAX);
  assign cntInc = CNT + WIDTH'(1);

  // Next-state and next-output logic. Everything holds by default; IC wins
  // over whatever the current state would do, so the timer restarts from any
  // state. The increment only happens in the RUN states, which are left as
  // soon as LONG_CYCLES is reached, so CNT can never pass LONG_CYCLES.
  always_comb begin
    stateNext     = state;
    prescalerNext = prescaler;
    cntNext       = CNT;
    sNext         = S;
    lNext         = L;
    if (IC) begin
      stateNext     = RUN_S;
      prescalerNext = '0;
      cntNext       = '0;
      sNext         = 1'b0;
      lNext         = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prescalerNext = '0;
          cntNext       = '0;
          sNext         = 1'b0;
          lNext         = 1'b0;
        end
        RUN_S: begin
          prescalerNext = tick ? '0 : prescaler + PW'(1);
          if (tick) begin
            cntNext = cntInc;
            if (cntInc == SHORT_W) begin
              sNext     = 1'b1;
              stateNext = RUN_L;
            end
          end
        end
        RUN_L: begin
          prescalerNext = tick ? '0 : prescaler + PW'(1);
          if (tick) begin
            cntNext = cntInc;
            if (cntInc == LONG_W) begin
              lNext     = 1'b1;
              stateNext = DONE;
            end
          end
        end
        DONE: begin
          prescalerNext = '0;
        end
        default: begin
          stateNext     = IDLE;
          prescalerNext = '0;
          cntNext       = '0;
          sNext         = 1'b0;
          lNext         = 1'b0;
        end
      endcase
    end
    busyNext = (stateNext == RUN_S) || (stateNext == RUN_L);
  end

  // State and output registers. Reset is synchronous and overrides IC, so a
  // reset edge always lands in IDLE with every flag cleared.
  always_ff @(posedge clk) begin
    if (!CLR) begin
      state     <= IDLE;
      prescaler <= '0;
      CNT       <= '0;
      S         <= 1'b0;
      L         <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= stateNext;
      prescaler <= prescalerNext;
      CNT       <= cntNext;
      S         <= sNext;
      L         <= lNext;
      BUSY      <= busyNext;
    end
  end

endmodule
